// File: rtl/hazard_scoreboard_unit.sv
// Pipeline hazard controller: per-register countdown scoreboard for RAW stalls,
// data-memory freeze FSM that holds flush pulses, and saturating perf counters.
module hazard_scoreboard_unit #(
  parameter int NREGS = 32,
  parameter int REGW  = 5,
  parameter int LATW  = 2,
  parameter int CNTW  = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            ihit,
  input  logic            dhit,
  input  logic            mem_req,
  input  logic            id_valid,
  input  logic [REGW-1:0] id_rs,
  input  logic [REGW-1:0] id_rt,
  input  logic            id_rs_used,
  input  logic            id_rt_used,
  input  logic            id_wr,
  input  logic [REGW-1:0] id_wsel,
  input  logic [LATW-1:0] id_lat,
  input  logic            branch_flush,
  input  logic            jump_flush,
  output logic            pcWEN,
  output logic            ifid_en,
  output logic            ifid_flush,
  output logic            idex_en,
  output logic            idex_flush,
  output logic            exmem_en,
  output logic            exmem_flush,
  output logic            memwb_en,
  output logic [CNTW-1:0] stall_cycles,
  output logic [CNTW-1:0] flush_count
);

  typedef enum logic {RUN, DWAIT} state_t;

  state_t state, state_nxt;
  logic pend_b, pend_j, pend_b_nxt, pend_j_nxt;

  logic [LATW-1:0] cnt [NREGS];
  logic [LATW-1:0] cnt_rs, cnt_rt;

  logic freeze, adv, fl_b, fl_j, flush_any;
  logic raw, raw_stall, issue, wsel_ok;

  assign freeze    = mem_req & ~dhit;
  assign adv       = ~freeze;
  assign fl_b      = branch_flush | pend_b;
  assign fl_j      = jump_flush | pend_j;
  assign flush_any = fl_b | fl_j;

  // Out-of-range selects (only possible when NREGS < 2**REGW) read as idle.
  assign cnt_rs  = (int'(id_rs) < NREGS) ? cnt[id_rs] : '0;
  assign cnt_rt  = (int'(id_rt) < NREGS) ? cnt[id_rt] : '0;
  assign wsel_ok = (id_wsel != '0) && (int'(id_wsel) < NREGS);

  assign raw = id_valid &
               ((id_rs_used & (id_rs != '0) & (cnt_rs != '0)) |
                (id_rt_used & (id_rt != '0) & (cnt_rt != '0)));

  assign raw_stall = adv & ~flush_any & raw;
  assign issue     = adv & id_valid & id_wr & wsel_ok & ~raw & ~flush_any;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= RUN;
      pend_b <= 1'b0;
      pend_j <= 1'b0;
    end else begin
      state  <= state_nxt;
      pend_b <= pend_b_nxt;
      pend_j <= pend_j_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    pend_b_nxt = pend_b;
    pend_j_nxt = pend_j;
    case (state)
      RUN: begin
        if (freeze) begin
          state_nxt  = DWAIT;
          pend_b_nxt = branch_flush;
          pend_j_nxt = jump_flush;
        end
      end
      DWAIT: begin
        if (freeze) begin
          pend_b_nxt = pend_b | branch_flush;
          pend_j_nxt = pend_j | jump_flush;
        end else begin
          // Releasing cycle applies the held flushes, so they are consumed here.
          state_nxt  = RUN;
          pend_b_nxt = 1'b0;
          pend_j_nxt = 1'b0;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    pcWEN       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_en     = 1'b1;
    idex_flush  = 1'b0;
    exmem_en    = 1'b1;
    exmem_flush = 1'b0;
    memwb_en    = 1'b1;
    if (RST) begin
      pcWEN       = 1'b0;
      ifid_en     = 1'b0;
      ifid_flush  = 1'b1;
      idex_en     = 1'b0;
      idex_flush  = 1'b1;
      exmem_en    = 1'b0;
      exmem_flush = 1'b1;
      memwb_en    = 1'b0;
    end else if (freeze) begin
      pcWEN    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
    end else if (flush_any) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = fl_b;
    end else if (raw_stall) begin
      pcWEN      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end else if (!ihit) begin
      pcWEN      = 1'b0;
      ifid_flush = 1'b1;
    end
  end

  // Branch flush kills every in-flight producer younger than the branch.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NREGS; i++) cnt[i] <= '0;
    end else if (adv) begin
      for (int i = 0; i < NREGS; i++) begin
        if (fl_b || i == 0)
          cnt[i] <= '0;
        else if (cnt[i] != '0)
          cnt[i] <= cnt[i] - LATW'(1);
      end
      if (issue) cnt[id_wsel] <= id_lat;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!pcWEN && stall_cycles != '1)
        stall_cycles <= stall_cycles + CNTW'(1);
      if (adv && flush_any && flush_count != '1)
        flush_count <= flush_count + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Bench for hazard_scoreboard_unit: directed vector table, then random traffic
// against a ready-time reference model, plus a 4-bit counter saturation run.
module tb_hazard_scoreboard_unit;

  localparam logic [7:0] C_RESET  = 8'b0010_1010;
  localparam logic [7:0] C_NORMAL = 8'b1101_0101;
  localparam logic [7:0] C_FREEZE = 8'b0000_0000;
  localparam logic [7:0] C_STALL  = 8'b0001_1101;
  localparam logic [7:0] C_MISS   = 8'b0111_0101;
  localparam logic [7:0] C_FLB    = 8'b1111_1111;
  localparam logic [7:0] C_FLJ    = 8'b1111_1101;

  logic CLK = 1'b0;
  logic RST, ihit, dhit, mem_req, id_valid;
  logic [4:0] id_rs, id_rt, id_wsel;
  logic id_rs_used, id_rt_used, id_wr;
  logic [1:0] id_lat;
  logic branch_flush, jump_flush;

  logic pcWEN, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en;
  logic [31:0] stall_cycles, flush_count;
  logic s_pc, s_ifid_en, s_ifid_fl, s_idex_en, s_idex_fl, s_exmem_en, s_exmem_fl, s_memwb_en;
  logic [3:0] s_stall, s_flush;

  hazard_scoreboard_unit u_dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .mem_req(mem_req),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_wr(id_wr),
    .id_wsel(id_wsel), .id_lat(id_lat),
    .branch_flush(branch_flush), .jump_flush(jump_flush),
    .pcWEN(pcWEN), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_en(idex_en), .idex_flush(idex_flush), .exmem_en(exmem_en),
    .exmem_flush(exmem_flush), .memwb_en(memwb_en),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  hazard_scoreboard_unit #(.CNTW(4)) u_sat (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .mem_req(mem_req),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_wr(id_wr),
    .id_wsel(id_wsel), .id_lat(id_lat),
    .branch_flush(branch_flush), .jump_flush(jump_flush),
    .pcWEN(s_pc), .ifid_en(s_ifid_en), .ifid_flush(s_ifid_fl),
    .idex_en(s_idex_en), .idex_flush(s_idex_fl), .exmem_en(s_exmem_en),
    .exmem_flush(s_exmem_fl), .memwb_en(s_memwb_en),
    .stall_cycles(s_stall), .flush_count(s_flush)
  );

  always #5 CLK = ~CLK;

  logic [7:0] ctl_now, s_ctl_now;
  assign ctl_now   = {pcWEN, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en};
  assign s_ctl_now = {s_pc, s_ifid_en, s_ifid_fl, s_idex_en, s_idex_fl, s_exmem_en, s_exmem_fl, s_memwb_en};

  int n_pass = 0;
  int n_total = 0;

  // Reference model: a register is busy until a given count of advancing cycles has elapsed.
  longint adv_n;
  longint ready_at [32];
  bit     m_pb, m_pj, m_known;
  longint m_stalls, m_flushes;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  function automatic bit m_busy(input logic [4:0] r);
    return (r != 0) && (adv_n < ready_at[r]);
  endfunction

  function automatic bit m_raw();
    return id_valid && ((id_rs_used && m_busy(id_rs)) || (id_rt_used && m_busy(id_rt)));
  endfunction

  function automatic logic [7:0] m_eval();
    bit fb, fj;
    if (RST) return C_RESET;
    if (mem_req && !dhit) return C_FREEZE;
    fb = branch_flush | m_pb;
    fj = jump_flush | m_pj;
    if (fb) return C_FLB;
    if (fj) return C_FLJ;
    if (m_raw()) return C_STALL;
    if (!ihit) return C_MISS;
    return C_NORMAL;
  endfunction

  task automatic m_update(input logic [7:0] mctl);
    bit fb, fj, raw;
    if (RST) begin
      adv_n = 0; m_pb = 0; m_pj = 0; m_stalls = 0; m_flushes = 0; m_known = 1;
      foreach (ready_at[i]) ready_at[i] = 0;
      return;
    end
    if (!mctl[7]) m_stalls++;
    if (mem_req && !dhit) begin
      m_pb |= branch_flush;
      m_pj |= jump_flush;
    end else begin
      fb  = branch_flush | m_pb;
      fj  = jump_flush | m_pj;
      raw = m_raw();
      if (fb || fj) m_flushes++;
      if (fb) foreach (ready_at[i]) ready_at[i] = 0;
      if (id_valid && id_wr && id_wsel != 0 && !raw && !(fb || fj))
        ready_at[id_wsel] = adv_n + 1 + longint'(id_lat);
      adv_n++;
      m_pb = 0; m_pj = 0;
    end
  endtask

  function automatic longint sat15(input longint v);
    return (v > 15) ? 15 : v;
  endfunction

  // Inputs are already driven; check mid-cycle, then advance the model at the edge.
  task automatic tick(input bit has_exp, input logic [7:0] ectl, input int est, input int efl);
    logic [7:0] mctl;
    #1;
    mctl = m_eval();
    chk("ctl_model", ctl_now, mctl);
    chk("ctl_sat_inst", s_ctl_now, mctl);
    if (m_known) begin
      chk("stall_model", stall_cycles, m_stalls);
      chk("flush_model", flush_count, m_flushes);
      chk("stall_sat4", s_stall, sat15(m_stalls));
      chk("flush_sat4", s_flush, sat15(m_flushes));
    end
    if (has_exp) begin
      chk("ctl_table", ctl_now, ectl);
      if (est >= 0) chk("stall_table", stall_cycles, est);
      if (efl >= 0) chk("flush_table", flush_count, efl);
    end
    @(posedge CLK);
    m_update(mctl);
    #1;
  endtask

  typedef struct {
    logic rst, ihit, dhit, mem_req, valid;
    logic [4:0] rs, rt;
    logic rs_used, rt_used, wr;
    logic [4:0] wsel;
    logic [1:0] lat;
    logic bf, jf;
    logic [7:0] ctl;
    int stall, flush;
  } vec_t;

  function automatic vec_t mkv(input logic [7:0] ctl, input int st, input int fl);
    vec_t v;
    v.rst = 0; v.ihit = 1; v.dhit = 0; v.mem_req = 0; v.valid = 0;
    v.rs = 0; v.rt = 0; v.rs_used = 0; v.rt_used = 0; v.wr = 0;
    v.wsel = 0; v.lat = 0; v.bf = 0; v.jf = 0;
    v.ctl = ctl; v.stall = st; v.flush = fl;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    RST = v.rst; ihit = v.ihit; dhit = v.dhit; mem_req = v.mem_req;
    id_valid = v.valid; id_rs = v.rs; id_rt = v.rt;
    id_rs_used = v.rs_used; id_rt_used = v.rt_used; id_wr = v.wr;
    id_wsel = v.wsel; id_lat = v.lat; branch_flush = v.bf; jump_flush = v.jf;
  endtask

  vec_t tbl[$];

  initial begin
    vec_t v;
    m_known = 0; m_pb = 0; m_pj = 0; adv_n = 0; m_stalls = 0; m_flushes = 0;
    foreach (ready_at[i]) ready_at[i] = 0;

    v = mkv(C_RESET, -1, -1); v.rst = 1; tbl.push_back(v);
    v = mkv(C_RESET, 0, 0);   v.rst = 1; tbl.push_back(v);
    v = mkv(C_RESET, 0, 0);   v.rst = 1; tbl.push_back(v);
    v = mkv(C_NORMAL, 0, 0);  tbl.push_back(v);
    // load-use on r8, then r0 source and unused rt
    v = mkv(C_NORMAL, 0, 0);  v.valid = 1; v.wr = 1; v.wsel = 8; v.lat = 1; tbl.push_back(v);
    v = mkv(C_STALL, 0, 0);   v.valid = 1; v.rs = 8; v.rs_used = 1; tbl.push_back(v);
    v = mkv(C_NORMAL, 1, 0);  v.valid = 1; v.rs = 8; v.rs_used = 1; tbl.push_back(v);
    v = mkv(C_NORMAL, 1, 0);  v.valid = 1; v.wr = 1; v.wsel = 8; v.lat = 1; tbl.push_back(v);
    v = mkv(C_NORMAL, 1, 0);  v.valid = 1; v.rs = 0; v.rs_used = 1; v.rt = 8; tbl.push_back(v);
    v = mkv(C_NORMAL, 1, 0);  tbl.push_back(v);
    // 4-cycle data wait, branch pulse in 2nd cycle, released on dhit
    v = mkv(C_FREEZE, 1, 0);  v.mem_req = 1; tbl.push_back(v);
    v = mkv(C_FREEZE, 2, 0);  v.mem_req = 1; v.bf = 1; tbl.push_back(v);
    v = mkv(C_FREEZE, 3, 0);  v.mem_req = 1; tbl.push_back(v);
    v = mkv(C_FREEZE, 4, 0);  v.mem_req = 1; tbl.push_back(v);
    v = mkv(C_FLB, 5, 0);     v.mem_req = 1; v.dhit = 1; tbl.push_back(v);
    v = mkv(C_NORMAL, 5, 1);  tbl.push_back(v);
    // jump kills the writer of r9
    v = mkv(C_FLJ, 5, 1);     v.valid = 1; v.wr = 1; v.wsel = 9; v.lat = 1; v.jf = 1; tbl.push_back(v);
    v = mkv(C_NORMAL, 5, 2);  v.valid = 1; v.rs = 9; v.rs_used = 1; tbl.push_back(v);
    // branch clears a 2-cycle producer of r5
    v = mkv(C_NORMAL, 5, 2);  v.valid = 1; v.wr = 1; v.wsel = 5; v.lat = 2; tbl.push_back(v);
    v = mkv(C_FLB, 5, 2);     v.bf = 1; tbl.push_back(v);
    v = mkv(C_NORMAL, 5, 3);  v.valid = 1; v.rt = 5; v.rt_used = 1; tbl.push_back(v);
    // flush beats a RAW hazard in the same cycle
    v = mkv(C_NORMAL, 5, 3);  v.valid = 1; v.wr = 1; v.wsel = 6; v.lat = 1; tbl.push_back(v);
    v = mkv(C_FLJ, 5, 3);     v.valid = 1; v.rs = 6; v.rs_used = 1; v.jf = 1; tbl.push_back(v);
    v = mkv(C_NORMAL, 5, 4);  v.valid = 1; v.rs = 6; v.rs_used = 1; tbl.push_back(v);
    // both flush pulses together count once, as a branch
    v = mkv(C_FLB, 5, 4);     v.bf = 1; v.jf = 1; tbl.push_back(v);
    v = mkv(C_NORMAL, 5, 5);  tbl.push_back(v);
    v = mkv(C_MISS, 5, 5);    v.ihit = 0; tbl.push_back(v);
    v = mkv(C_NORMAL, 6, 5);  tbl.push_back(v);
    v = mkv(C_NORMAL, 6, 5);  v.mem_req = 1; v.dhit = 1; tbl.push_back(v);
    v = mkv(C_NORMAL, 6, 5);  tbl.push_back(v);
    // reset while a jump is pending in the wait state
    v = mkv(C_FREEZE, 6, 5);  v.mem_req = 1; v.jf = 1; tbl.push_back(v);
    v = mkv(C_RESET, 7, 5);   v.rst = 1; v.mem_req = 1; tbl.push_back(v);
    v = mkv(C_NORMAL, 0, 0);  tbl.push_back(v);
    v = mkv(C_NORMAL, 0, 0);  tbl.push_back(v);

    drive(tbl[0]);
    #2;
    foreach (tbl[i]) begin
      drive(tbl[i]);
      tick(1'b1, tbl[i].ctl, tbl[i].stall, tbl[i].flush);
    end

    for (int n = 0; n < 3000; n++) begin
      RST          = ($urandom_range(99, 0) < 1);
      ihit         = ($urandom_range(99, 0) < 85);
      mem_req      = ($urandom_range(99, 0) < 30);
      dhit         = ($urandom_range(99, 0) < 50);
      id_valid     = ($urandom_range(99, 0) < 80);
      id_rs        = 5'($urandom_range(7, 0));
      id_rt        = 5'($urandom_range(7, 0));
      id_rs_used   = $urandom_range(1, 0) == 1;
      id_rt_used   = $urandom_range(1, 0) == 1;
      id_wr        = $urandom_range(1, 0) == 1;
      id_wsel      = 5'($urandom_range(7, 0));
      id_lat       = 2'($urandom_range(3, 0));
      branch_flush = ($urandom_range(99, 0) < 7);
      jump_flush   = ($urandom_range(99, 0) < 7);
      tick(1'b0, 8'h00, -1, -1);
    end

    // saturation: 20 fetch-miss cycles after a reset
    drive(mkv(C_RESET, 0, 0));
    RST = 1;
    tick(1'b1, C_RESET, -1, -1);
    RST = 0; ihit = 0;
    for (int n = 0; n < 20; n++) tick(1'b1, C_MISS, n, 0);
    ihit = 1;
    #1;
    chk("stall_sat_hold", s_stall, 15);
    chk("stall_wide_20", stall_cycles, 20);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
